mcu_timer_bank: RTL and testbench

- Parametrised successor to the MCU's single STM/TTM timer.
- Provides NCH independent timer channels. Each channel pairs a free-running PRE_W-bit prescaler (polynomial-counter equivalent) with a CNT_W-bit down counter.
- Each channel runs in one-shot (legacy STM) or periodic auto-reload mode, and has a sticky TM flag, an overrun flag and a maskable interrupt request.
- Sits beside the core and is advanced by the core's instruction-cycle strobe (tick = clk_mcu).

---
 rtl/mcu_timer_pkg.sv | 12 +
 rtl/mcu_timer_chan.sv | 106 ++++++++++
 rtl/mcu_timer_bank.sv | 61 ++++++
 tb/tb_mcu_timer_bank.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_timer_pkg.sv
// Shared definitions for the MCU timer bank: channel mode encoding and default widths.
package mcu_timer_pkg;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } tmr_mode_e;

    localparam int unsigned PRE_W_DEF = 6;
    localparam int unsigned CNT_W_DEF = 6;

endpackage

// File: rtl/mcu_timer_chan.sv
// One timer channel: free-running prescaler feeding a down counter with reload,
// one-shot/periodic mode, sticky expiry (tm) and overrun (ovr) flags.
module mcu_timer_chan
    import mcu_timer_pkg::*;
#(
    parameter int unsigned PRE_W = PRE_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             load_mode_i,
    input  logic             tm_clr_i,
    output logic             tm_o,
    output logic             ovr_o,
    output logic             running_o,
    output logic             tm_nxt_o
);

    logic [PRE_W-1:0] pcount_q, pcount_d;
    logic [CNT_W-1:0] bcount_q, bcount_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    tmr_mode_e        mode_q, mode_d;
    logic             tm_q, tm_d;
    logic             ovr_q, ovr_d;
    logic             run_q, run_d;
    logic             expire;

    always_comb begin
        pcount_d = pcount_q;
        bcount_d = bcount_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tm_d     = tm_q;
        ovr_d    = ovr_q;
        run_d    = run_q;
        expire   = 1'b0;

        if (tick_i) begin
            if (load_i) begin
                pcount_d = '0;
                bcount_d = load_val_i;
                reload_d = load_val_i;
                mode_d   = tmr_mode_e'(load_mode_i);
                tm_d     = 1'b0;
                ovr_d    = 1'b0;
                run_d    = 1'b1;
            end else begin
                if (run_q) begin
                    pcount_d = pcount_q + 1'b1;
                    if (&pcount_q) begin
                        if (bcount_q == '0) begin
                            expire = 1'b1;
                        end else begin
                            bcount_d = bcount_q - 1'b1;
                        end
                    end
                end
                if (tm_clr_i) begin
                    tm_d  = 1'b0;
                    ovr_d = 1'b0;
                end
                // Expiry overrides a same-tick clear of tm; a clear still suppresses overrun.
                if (expire) begin
                    tm_d = 1'b1;
                    if (tm_q && !tm_clr_i && (mode_q == MODE_PERIODIC)) begin
                        ovr_d = 1'b1;
                    end
                    if (mode_q == MODE_PERIODIC) begin
                        bcount_d = reload_q;
                    end else begin
                        run_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcount_q <= '0;
            bcount_q <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tm_q     <= 1'b1;
            ovr_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            pcount_q <= pcount_d;
            bcount_q <= bcount_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tm_q     <= tm_d;
            ovr_q    <= ovr_d;
            run_q    <= run_d;
        end
    end

    assign tm_o      = tm_q;
    assign ovr_o     = ovr_q;
    assign running_o = run_q;
    assign tm_nxt_o  = tm_d;

endmodule

// File: rtl/mcu_timer_bank.sv
// Bank of NCH independent timer channels advanced by the core tick strobe,
// with a registered, maskable interrupt request ORed across channels.
module mcu_timer_bank
    import mcu_timer_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned PRE_W = PRE_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [NCH-1:0]   load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             load_mode,
    input  logic [NCH-1:0]   tm_clr,
    input  logic [NCH-1:0]   irq_en,
    output logic [NCH-1:0]   tm,
    output logic [NCH-1:0]   ovr,
    output logic [NCH-1:0]   running,
    output logic             irq
);

    logic [NCH-1:0] tm_nxt;
    logic           irq_q, irq_d;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mcu_timer_chan #(
            .PRE_W (PRE_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (reset),
            .tick_i      (tick),
            .load_i      (load[i]),
            .load_val_i  (load_val),
            .load_mode_i (load_mode),
            .tm_clr_i    (tm_clr[i]),
            .tm_o        (tm[i]),
            .ovr_o       (ovr[i]),
            .running_o   (running[i]),
            .tm_nxt_o    (tm_nxt[i])
        );
    end

    // Sampled every clk, not only on tick, so mask changes take effect promptly.
    always_comb begin
        irq_d = |(tm_nxt & irq_en);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_mcu_timer_bank.sv
// Directed self-checking bench for mcu_timer_bank (NCH=2, PRE_W=6, CNT_W=6).
module tb_mcu_timer_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] load = '0;
    logic [5:0] load_val = '0;
    logic       load_mode = 1'b0;
    logic [1:0] tm_clr = '0;
    logic [1:0] irq_en = '0;
    logic [1:0] tm, ovr, running;
    logic       irq;

    int checks = 0;
    int errors = 0;

    mcu_timer_bank #(
        .NCH   (2),
        .PRE_W (6),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .load_val  (load_val),
        .load_mode (load_mode),
        .tm_clr    (tm_clr),
        .irq_en    (irq_en),
        .tm        (tm),
        .ovr       (ovr),
        .running   (running),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) clk1();
    endtask

    task automatic do_load(input logic [1:0] m, input logic [5:0] v, input logic md);
        load      = m;
        load_val  = v;
        load_mode = md;
        tick      = 1'b1;
        clk1();
        load      = '0;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        run(3);
        chk("rst_tm", tm, 2'b11);
        chk("rst_running", running, 2'b00);
        chk("rst_ovr", ovr, 2'b00);
        chk("rst_irq", irq, 1'b0);
        reset = 1'b1;
        clk1();
        chk("rel_tm", tm, 2'b11);
        chk("rel_running", running, 2'b00);
        irq_en = 2'b01;
        clk1();
        chk("irq_en_rise", irq, 1'b1);
        irq_en = 2'b00;
        clk1();
        chk("irq_en_drop", irq, 1'b0);

        // Ch0 one-shot, load_val=0: expires 64 ticks after load
        do_load(2'b01, 6'd0, 1'b0);
        chk("os_load_tm", tm, 2'b10);
        chk("os_load_run", running, 2'b01);
        run(63);
        chk("os_t63_tm0", tm[0], 1'b0);
        run(1);
        chk("os_t64_tm0", tm[0], 1'b1);
        chk("os_t64_run0", running[0], 1'b0);
        run(200);
        chk("os_frozen_tm0", tm[0], 1'b1);
        chk("os_frozen_run0", running[0], 1'b0);
        chk("os_frozen_ovr", ovr, 2'b00);
        irq_en = 2'b01;
        clk1();
        chk("os_irq_on", irq, 1'b1);
        tm_clr = 2'b01;
        clk1();
        tm_clr = 2'b00;
        chk("os_clr_tm0", tm[0], 1'b0);
        chk("os_clr_irq", irq, 1'b0);
        irq_en = 2'b00;
        run(70);
        chk("os_stopped_tm0", tm[0], 1'b0);

        // Ch1 periodic, load_val=2: period 192 ticks
        do_load(2'b10, 6'd2, 1'b1);
        run(191);
        chk("per_t191_tm1", tm[1], 1'b0);
        run(1);
        chk("per_t192_tm1", tm[1], 1'b1);
        run(7);
        tm_clr = 2'b10;
        clk1();
        tm_clr = 2'b00;
        chk("per_t200_clr_tm1", tm[1], 1'b0);
        run(183);
        chk("per_t383_tm1", tm[1], 1'b0);
        run(1);
        chk("per_t384_tm1", tm[1], 1'b1);
        chk("per_t384_ovr1", ovr[1], 1'b0);
        run(191);
        chk("per_t575_ovr1", ovr[1], 1'b0);
        run(1);
        chk("per_t576_ovr1", ovr[1], 1'b1);
        chk("per_t576_tm1", tm[1], 1'b1);
        chk("per_t576_run1", running[1], 1'b1);

        // Sparse tick: every 4th clk, load_val=1 -> 128 ticks = 512 clks
        tm_clr = 2'b11;
        clk1();
        tm_clr = 2'b00;
        do_load(2'b01, 6'd1, 1'b0);
        for (int j = 1; j <= 512; j++) begin
            tick     = ((j % 4) == 0);
            load     = tick ? 2'b00 : 2'b01;
            tm_clr   = tick ? 2'b00 : 2'b01;
            load_val = 6'd63;
            clk1();
            if (j == 511) chk("sparse_c511_tm0", tm[0], 1'b0);
            if (j == 512) begin
                chk("sparse_c512_tm0", tm[0], 1'b1);
                chk("sparse_c512_run0", running[0], 1'b0);
            end
        end
        load   = 2'b00;
        tm_clr = 2'b00;
        tick   = 1'b1;

        // Collision: tm_clr with expiry (periodic, load_val=0)
        do_load(2'b01, 6'd0, 1'b1);
        run(63);
        chk("col_t63_tm0", tm[0], 1'b0);
        run(1);
        chk("col_t64_tm0", tm[0], 1'b1);
        chk("col_t64_ovr0", ovr[0], 1'b0);
        run(63);
        tm_clr = 2'b01;
        clk1();
        tm_clr = 2'b00;
        chk("col_clr_exp_tm0", tm[0], 1'b1);
        chk("col_clr_exp_ovr0", ovr[0], 1'b0);
        run(64);
        chk("col_t192_ovr0", ovr[0], 1'b1);

        // Collision: load with expiry (new value 1, one-shot)
        run(63);
        do_load(2'b01, 6'd1, 1'b0);
        chk("col_ld_exp_tm0", tm[0], 1'b0);
        chk("col_ld_exp_ovr0", ovr[0], 1'b0);
        chk("col_ld_exp_run0", running[0], 1'b1);
        run(127);
        chk("col_ld_t127_tm0", tm[0], 1'b0);
        run(1);
        chk("col_ld_t128_tm0", tm[0], 1'b1);
        chk("col_ld_t128_run0", running[0], 1'b0);

        // Collision: load with tm_clr
        tm_clr = 2'b01;
        do_load(2'b01, 6'd0, 1'b1);
        tm_clr = 2'b00;
        chk("col_ld_clr_tm0", tm[0], 1'b0);
        chk("col_ld_clr_run0", running[0], 1'b1);
        chk("col_ld_clr_ovr0", ovr[0], 1'b0);
        run(63);
        chk("col_ld_clr_t63", tm[0], 1'b0);
        run(1);
        chk("col_ld_clr_t64", tm[0], 1'b1);

        // Reset mid-count
        do_load(2'b01, 6'd3, 1'b1);
        run(99);
        irq_en = 2'b11;
        clk1();
        reset = 1'b0;
        #1;
        chk("midrst_tm", tm, 2'b11);
        chk("midrst_running", running, 2'b00);
        chk("midrst_ovr", ovr, 2'b00);
        chk("midrst_irq", irq, 1'b0);
        irq_en = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        clk1();
        chk("post_rst_tm", tm, 2'b11);
        chk("post_rst_running", running, 2'b00);
        do_load(2'b01, 6'd0, 1'b0);
        run(63);
        chk("post_rst_t63", tm[0], 1'b0);
        run(1);
        chk("post_rst_t64", tm[0], 1'b1);
        chk("post_rst_run0", running[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
